kvaz_wrpost: RTL and testbench

//  Write-posting buffer plus SDRAM request sequencer for the ramdisk (kvaz) path. It sits between
//  the Vector bus front end (kvaz_write/kvaz_read pulses, {page,decoded_a}) and SDRAM_Controller.

---
 rtl/kvaz_wrpost.sv | 201 ++++++++++++++++++++
 tb/tb_kvaz_wrpost.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kvaz_wrpost.sv
// kvaz_wrpost: write-posting FIFO and SDRAM request sequencer for the ramdisk path.
// Vector writes are queued and drained on free bus slots; Vector reads take priority
// and return one byte. Optional build macro KVAZ_WRPOST_FWD_EN enables read-after-write
// forwarding from the FIFO; without it a pending read waits for the FIFO to drain.
//
// Handshake: sdram_read/sdram_write are single-cycle requests with no ready; the access
// completes on the falling edge of sdram_busy, or after 4 idle cycles if busy never rises.
module kvaz_wrpost #(
  parameter int          DEPTH     = 4,
  parameter logic [21:0] BASE_WORD = 22'h005000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vu_write,
  input  logic        vu_read,
  input  logic [17:0] vu_adrs,
  input  logic [7:0]  vu_data,
  input  logic        access_slot,
  input  logic        sdram_busy,
  input  logic [15:0] sdram_dq,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_data,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic        sdram_lb,
  output logic        sdram_ub,
  output logic [7:0]  q,
  output logic        q_valid,
  output logic        overflow,
  output logic        pending,
  output logic [2:0]  state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  // FIFO storage: entry = {adrs, data}
  logic [25:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  // FSM and registered outputs
  state_t        state_q;
  logic          rd_pend_q;
  logic [17:0]   rd_adrs_q;
  logic [21:0]   addr_q;
  logic [15:0]   data_q;
  logic          rd_req_q, wr_req_q, lb_q, ub_q;
  logic [7:0]    q_q;
  logic          q_valid_q;
  logic          seen_busy_q;
  logic [1:0]    tmo_q;

  logic          fifo_empty, fifo_full, push, pop, wait_done, rd_go, wr_go;
  logic [25:0]   head;
  logic          fwd_hit;
  logic [7:0]    fwd_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // Access ends on busy falling edge, or after the busy-rise timeout expires
  assign wait_done = !sdram_busy && (seen_busy_q || (tmo_q == 2'd3));
  assign pop       = (state_q == WR_WAIT) && wait_done;
  assign push      = vu_write && (!fifo_full || pop);

`ifdef KVAZ_WRPOST_FWD_EN
  // Search oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && mem_q[rd_ptr_q + PW'(i)][25:8] == vu_adrs) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[rd_ptr_q + PW'(i)][7:0];
      end
    end
  end
  assign rd_go = rd_pend_q && !sdram_busy;
  assign wr_go = !rd_go && !fifo_empty && access_slot && !sdram_busy;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // A pending read lets the FIFO drain without bus slots, then goes out
  assign rd_go = rd_pend_q && fifo_empty && !sdram_busy;
  assign wr_go = !fifo_empty && (access_slot || rd_pend_q) && !sdram_busy;
`endif

  // FIFO data array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {vu_adrs, vu_data};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (vu_write && !push) overflow_q <= 1'b1;
    end
  end

  // Request sequencer with registered SDRAM outputs, read latch and read-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      rd_adrs_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      lb_q        <= 1'b0;
      ub_q        <= 1'b0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      seen_busy_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      q_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          seen_busy_q <= 1'b0;
          tmo_q       <= '0;
          if (rd_go) begin
            state_q  <= RD_REQ;
            rd_req_q <= 1'b1;
            addr_q   <= BASE_WORD + {5'b0, rd_adrs_q[17:1]};
            data_q   <= '0;
            lb_q     <= ~rd_adrs_q[0];
            ub_q     <= rd_adrs_q[0];
          end else if (wr_go) begin
            state_q  <= WR_REQ;
            wr_req_q <= 1'b1;
            addr_q   <= BASE_WORD + {5'b0, head[25:9]};
            data_q   <= {head[7:0], head[7:0]};
            lb_q     <= ~head[8];
            ub_q     <= head[8];
          end
        end
        RD_REQ: state_q <= RD_WAIT;
        WR_REQ: state_q <= WR_WAIT;
        RD_WAIT, WR_WAIT: begin
          if (sdram_busy) seen_busy_q <= 1'b1;
          else if (!seen_busy_q && tmo_q != 2'd3) tmo_q <= tmo_q + 2'd1;
          if (wait_done) begin
            state_q <= IDLE;
            if (state_q == RD_WAIT) begin
              q_q       <= ub_q ? sdram_dq[15:8] : sdram_dq[7:0];
              q_valid_q <= 1'b1;
              rd_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // New reads override completion bookkeeping on the same edge
      if (vu_read) begin
        if (fwd_hit) begin
          q_q       <= fwd_data;
          q_valid_q <= 1'b1;
        end else begin
          rd_pend_q <= 1'b1;
          rd_adrs_q <= vu_adrs;
        end
      end
    end
  end

  assign sdram_addr  = addr_q;
  assign sdram_data  = data_q;
  assign sdram_read  = rd_req_q;
  assign sdram_write = wr_req_q;
  assign sdram_lb    = lb_q;
  assign sdram_ub    = ub_q;
  assign q           = q_q;
  assign q_valid     = q_valid_q;
  assign overflow    = overflow_q;
  assign pending     = !fifo_empty || (state_q != IDLE) || rd_pend_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_kvaz_wrpost.sv
// Directed bench for kvaz_wrpost: posted writes, overflow, read priority/ordering,
// forwarding (when KVAZ_WRPOST_FWD_EN is defined), busy timeout and mid-access reset.
module tb_kvaz_wrpost;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vu_write = 1'b0, vu_read = 1'b0, access_slot = 1'b0;
  logic [17:0] vu_adrs = '0;
  logic [7:0]  vu_data = '0;
  logic        sdram_busy = 1'b0;
  logic [15:0] sdram_dq = '0;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        sdram_read, sdram_write, sdram_lb, sdram_ub;
  logic [7:0]  q;
  logic        q_valid, overflow, pending;
  logic [2:0]  state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  int          qv_cnt = 0;
  logic [63:0] exp_q[$];
  logic [15:0] resp_dq = '0;
  bit          resp_silent = 1'b0;

  kvaz_wrpost dut (
    .clk(clk), .reset_n(reset_n), .vu_write(vu_write), .vu_read(vu_read),
    .vu_adrs(vu_adrs), .vu_data(vu_data), .access_slot(access_slot),
    .sdram_busy(sdram_busy), .sdram_dq(sdram_dq), .sdram_addr(sdram_addr),
    .sdram_data(sdram_data), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_lb(sdram_lb), .sdram_ub(sdram_ub), .q(q), .q_valid(q_valid),
    .overflow(overflow), .pending(pending), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_txn(input bit is_wr, input logic [21:0] a,
                                         input logic [15:0] d, input bit lb, input bit ub);
    return {23'b0, is_wr, a, d, lb, ub};
  endfunction

  // SDRAM responder and scoreboard: every request is compared with the expected queue
  initial begin
    logic [63:0] got, exp;
    forever begin
      @(negedge clk);
      if (sdram_read || sdram_write) begin
        got = mk_txn(sdram_write, sdram_addr, sdram_write ? sdram_data : 16'h0, sdram_lb, sdram_ub);
        if (exp_q.size() == 0) chk("unexpected_req", got, 64'h0);
        else begin
          exp = exp_q.pop_front();
          chk("sdram_req", got, exp);
        end
        if (resp_silent) sdram_dq = resp_dq;
        else begin
          sdram_busy = 1'b1;
          repeat (3) @(negedge clk);
          sdram_dq   = resp_dq;
          sdram_busy = 1'b0;
        end
      end
    end
  end

  // q_valid pulse monitor
  initial forever begin
    @(negedge clk);
    if (q_valid) qv_cnt++;
  end

  // Driver tasks
  task automatic do_write(input logic [17:0] a, input logic [7:0] d);
    @(negedge clk);
    vu_write = 1'b1; vu_adrs = a; vu_data = d;
    @(negedge clk);
    vu_write = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a);
    @(negedge clk);
    vu_read = 1'b1; vu_adrs = a;
    @(negedge clk);
    vu_read = 1'b0;
  endtask

  task automatic do_slot();
    @(negedge clk);
    access_slot = 1'b1;
    @(negedge clk);
    access_slot = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (!pending && !sdram_busy) return;
    end
    chk("tmo_idle", {63'b0, pending}, 64'h0);
  endtask

  task automatic wait_fsm_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (state_dbg == 3'd0 && !sdram_busy) return;
    end
    chk("tmo_fsm_idle", {61'b0, state_dbg}, 64'h0);
  endtask

  task automatic wait_qv(input int max);
    int start;
    start = qv_cnt;
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (qv_cnt != start) return;
    end
    chk("tmo_qv", qv_cnt, start + 1);
  endtask

  task automatic wait_rd_busy(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk); #1;
      if (state_dbg == 3'd2 && sdram_busy) return;
    end
    chk("tmo_rd_wait", {61'b0, state_dbg}, 64'h2);
  endtask

  initial begin
    int qv_before;
    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1'b1;

    // Single posted write drained on a slot
    do_write(18'h01235, 8'hA5);
    #1 chk("t1_pending", pending, 1);
    exp_q.push_back(mk_txn(1, 22'h00591A, 16'hA5A5, 0, 1));
    do_slot();
    wait_idle(40);
    chk("t1_drained", exp_q.size(), 0);

    // Five writes into a 4-deep FIFO, then four slots
    for (int i = 0; i < 5; i++) do_write(18'h00100 + 18'(i), 8'h10 + 8'(i));
    #1 chk("t2_overflow", overflow, 1);
    exp_q.push_back(mk_txn(1, 22'h005080, 16'h1010, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005080, 16'h1111, 0, 1));
    exp_q.push_back(mk_txn(1, 22'h005081, 16'h1212, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005081, 16'h1313, 0, 1));
    for (int i = 0; i < 4; i++) begin
      do_slot();
      wait_fsm_idle(40);
    end
    wait_idle(40);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_overflow_sticky", overflow, 1);

    // Two posted writes, then a read of an address not in the FIFO
    do_write(18'h00200, 8'h31);
    do_write(18'h00201, 8'h32);
    resp_dq = 16'h3C00;
`ifdef KVAZ_WRPOST_FWD_EN
    exp_q.push_back(mk_txn(0, 22'h005180, 16'h0, 0, 1));
    exp_q.push_back(mk_txn(1, 22'h005100, 16'h3131, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005100, 16'h3232, 0, 1));
    do_read(18'h00301);
    wait_qv(40);
    chk("t3_q", q, 8'h3C);
    wait_fsm_idle(40);
    for (int i = 0; i < 2; i++) begin
      do_slot();
      wait_fsm_idle(40);
    end
`else
    exp_q.push_back(mk_txn(1, 22'h005100, 16'h3131, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005100, 16'h3232, 0, 1));
    exp_q.push_back(mk_txn(0, 22'h005180, 16'h0, 0, 1));
    do_read(18'h00301);
    wait_qv(80);
    chk("t3_q", q, 8'h3C);
`endif
    wait_idle(40);
    chk("t3_drained", exp_q.size(), 0);

    // Two writes to one address, then read it back
    do_write(18'h00010, 8'h11);
    do_write(18'h00010, 8'h22);
    resp_dq = 16'h5522;
`ifdef KVAZ_WRPOST_FWD_EN
    do_read(18'h00010);
    chk("t4_qv_1clk", q_valid, 1);
    chk("t4_q_fwd", q, 8'h22);
    exp_q.push_back(mk_txn(1, 22'h005008, 16'h1111, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005008, 16'h2222, 1, 0));
    for (int i = 0; i < 2; i++) begin
      do_slot();
      wait_fsm_idle(40);
    end
`else
    exp_q.push_back(mk_txn(1, 22'h005008, 16'h1111, 1, 0));
    exp_q.push_back(mk_txn(1, 22'h005008, 16'h2222, 1, 0));
    exp_q.push_back(mk_txn(0, 22'h005008, 16'h0, 1, 0));
    do_read(18'h00010);
    wait_qv(80);
    chk("t5_q", q, 8'h22);
`endif
    wait_idle(40);
    chk("t45_drained", exp_q.size(), 0);

    // Busy never rises: read completes on timeout with dq as sampled
    resp_silent = 1'b1;
    resp_dq = 16'hBEEF;
    exp_q.push_back(mk_txn(0, 22'h005002, 16'h0, 0, 1));
    do_read(18'h00005);
    wait_qv(30);
    chk("t7_q_timeout", q, 8'hBE);
    wait_idle(20);
    chk("t7_pending", pending, 0);
    resp_silent = 1'b0;

    // Reset while a read is waiting on busy
    resp_dq = 16'h7777;
    exp_q.push_back(mk_txn(0, 22'h005001, 16'h0, 0, 1));
    do_read(18'h00003);
    wait_rd_busy(20);
    reset_n = 1'b0;
    #1;
    chk("t6_q", q, 0);
    chk("t6_addr", sdram_addr, 0);
    chk("t6_ub", sdram_ub, 0);
    chk("t6_pending", pending, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    qv_before = qv_cnt;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_no_qv", qv_cnt, qv_before);
    chk("t6_pending_after", pending, 0);
    chk("end_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
